// File: rtl/pc_unit_param_if.sv
// Fetch-stage control/status bundle for pc_unit_param.
// master: the side that issues redirect/stall requests (hazard unit, decode, CP0).
// slave:  the PC unit itself.
interface pc_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [15:0]      branch_offset;
    logic             jump;
    logic [25:0]      jump_target;
    logic             jr;
    logic [WIDTH-1:0] jr_addr;
    logic             exc;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             pc_valid;
    logic             misalign;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               jr, jr_addr, exc, eret,
        input  pc, pc_plus4, epc, pc_valid, misalign
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               jr, jr_addr, exc, eret,
        output pc, pc_plus4, epc, pc_valid, misalign
    );
endinterface

// File: rtl/pc_unit_param.sv
// Parametrised MIPS fetch-stage program-counter unit.
// Holds the PC, selects the next PC from sequential / branch / jump / jr /
// exception / eret sources, captures EPC on exceptions and keeps fetch invalid
// during a post-reset boot window and the one-cycle flush after an exception.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, a misaligned jr
// target is trapped to the exception vector and flagged on misalign.
module pc_unit_param #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter logic [31:0]      EXC_VECTOR   = 32'h8000_0180,
    parameter int               BOOT_CYCLES  = 2
) (
    input logic            clk,
    input logic            Reset,
    pc_unit_param_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Which source wins the PC mux this edge.
    typedef enum logic [2:0] {
        SRC_HOLD   = 3'd0,
        SRC_SEQ    = 3'd1,
        SRC_EXC    = 3'd2,
        SRC_ERET   = 3'd3,
        SRC_JR     = 3'd4,
        SRC_JUMP   = 3'd5,
        SRC_BRANCH = 3'd6,
        SRC_TRAP   = 3'd7
    } src_t;

    localparam logic [WIDTH-1:0] EXC_VEC     = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] PC_STEP     = WIDTH'(3'd4);
    localparam state_t           RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
    localparam logic             RESET_VALID = (BOOT_CYCLES == 0) ? 1'b1 : 1'b0;
    localparam logic [7:0]       BOOT_LAST   = 8'(BOOT_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       boot_cnt_r;
    logic [7:0]       boot_cnt_nxt_s;
    src_t             src_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] epc_nxt_s;
    logic             pc_valid_r;
    logic             pc_valid_nxt_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] jump_pc_s;
    logic [WIDTH-1:0] branch_pc_s;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_r;
    logic             misalign_nxt_s;
`endif

    // Candidate targets; every add wraps modulo 2^WIDTH.
    assign pc_plus4_s  = pc_r + PC_STEP;
    assign jump_pc_s   = {pc_plus4_s[WIDTH-1:28], bus.jump_target, 2'b00};
    assign branch_pc_s = pc_plus4_s +
                         {{(WIDTH-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};

    // Priority select among redirect sources; only RUN accepts requests.
    always_comb begin
        src_s = SRC_HOLD;
        if (state_r != ST_RUN) begin
            src_s = SRC_HOLD;
        end else if (bus.exc) begin
            src_s = SRC_EXC;
        end else if (bus.eret) begin
            src_s = SRC_ERET;
        end else if (bus.stall) begin
            src_s = SRC_HOLD;
        end else if (bus.jr) begin
`ifdef PC_ALIGN_CHECK_EN
            if (bus.jr_addr[1:0] != 2'b00) begin
                src_s = SRC_TRAP;
            end else begin
                src_s = SRC_JR;
            end
`else
            src_s = SRC_JR;
`endif
        end else if (bus.jump) begin
            src_s = SRC_JUMP;
        end else if (bus.branch_taken) begin
            src_s = SRC_BRANCH;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // State register plus registered PC/EPC/valid datapath.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= RESET_STATE;
            boot_cnt_r <= 8'd0;
            pc_r       <= RESET_VECTOR;
            epc_r      <= {WIDTH{1'b0}};
            pc_valid_r <= RESET_VALID;
        end else begin
            state_r    <= state_nxt_s;
            boot_cnt_r <= boot_cnt_nxt_s;
            pc_r       <= pc_nxt_s;
            epc_r      <= epc_nxt_s;
            pc_valid_r <= pc_valid_nxt_s;
        end
    end

    // Next-state logic: BOOT counts edges, an exception or trap costs one FLUSH edge.
    always_comb begin
        state_nxt_s    = state_r;
        boot_cnt_nxt_s = boot_cnt_r;
        case (state_r)
            ST_BOOT: begin
                if (boot_cnt_r == BOOT_LAST) begin
                    state_nxt_s    = ST_RUN;
                    boot_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s    = ST_BOOT;
                    boot_cnt_nxt_s = boot_cnt_r + 8'd1;
                end
            end
            ST_RUN: begin
                if (src_s == SRC_EXC || src_s == SRC_TRAP) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s    = RESET_STATE;
                boot_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Output logic: next PC / EPC / misalign from the winning source.
    always_comb begin
        pc_nxt_s       = pc_r;
        epc_nxt_s      = epc_r;
`ifdef PC_ALIGN_CHECK_EN
        misalign_nxt_s = misalign_r;
`endif
        case (src_s)
            SRC_EXC: begin
                epc_nxt_s = pc_r;
                pc_nxt_s  = EXC_VEC;
            end
            SRC_TRAP: begin
                epc_nxt_s      = pc_r;
                pc_nxt_s       = EXC_VEC;
`ifdef PC_ALIGN_CHECK_EN
                misalign_nxt_s = 1'b1;
`endif
            end
            SRC_ERET: begin
                pc_nxt_s       = epc_r;
`ifdef PC_ALIGN_CHECK_EN
                misalign_nxt_s = 1'b0;
`endif
            end
            SRC_JR:     pc_nxt_s = bus.jr_addr;
            SRC_JUMP:   pc_nxt_s = jump_pc_s;
            SRC_BRANCH: pc_nxt_s = branch_pc_s;
            SRC_SEQ:    pc_nxt_s = pc_plus4_s;
            SRC_HOLD:   pc_nxt_s = pc_r;
            default:    pc_nxt_s = pc_r;
        endcase
        pc_valid_nxt_s = (state_nxt_s == ST_RUN) ? 1'b1 : 1'b0;
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky misaligned-jr flag, cleared by eret or Reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_nxt_s;
        end
    end

    assign bus.misalign = misalign_r;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc       = pc_r;
    assign bus.pc_plus4 = pc_plus4_s;
    assign bus.epc      = epc_r;
    assign bus.pc_valid = pc_valid_r;

endmodule
